alu_result_serializer: RTL and testbench
========================================

Name: alu_result_serializer

Overview:
- Downstream stage of the 4-bit ALU. Captures each ALU result and its carry and zero flags through a valid/ready handshake.
- Serialises each captured result onto a single output pin as a fixed UART-style frame, so that results can be read on one dedicated output.
- One result can be held while the previous frame is still shifting (double-buffered).

Parameters:
- WIDTH, 4: ALU result width in bits.
- CLKS_PER_BIT, 4: clock cycles each frame bit is held on tx_out. Must be ≥ 1.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous reset, active-high.
- res_valid  input  1  ALU result present on res_data, res_carry and res_zero.
- res_ready  output  1  holding register empty; a result is accepted this cycle.
- res_data  input  WIDTH  ALU result.
- res_carry  input  1  ALU carry/borrow flag.
- res_zero  input  1  ALU zero flag.
- tx_out  output  1  serial frame output; idles high.
- busy  output  1  a frame is shifting or a result is held.
- frame_count  output  8  number of completed frames; wraps.

Behaviour:
- Clocking: one clock, clk. rst is synchronous and active-high.
- Reset values: tx_out=1, res_ready=1, busy=0, frame_count=0. Holding register is empty. FSM is in IDLE.
- Frame format, WIDTH+5 bits, in transmit order:
  - start bit 0;
  - res_data, LSB first;
  - carry;
  - zero;
  - parity = XOR of the data, carry and zero bits (even parity: total ones across data, flags and parity is even);
  - stop bit 1.
- Handshake:
  - res_ready = !hold_valid. It is derived from registered state only and has no combinational path from res_valid.
  - Accept occurs on an edge where res_valid && res_ready. The result and flags are written to the holding register and hold_valid is set.
  - While res_ready=0, res_valid and the data are ignored. No overwrite and no loss of the held result.
- FSM states: IDLE and SHIFT. A bit-timer counts 0..CLKS_PER_BIT-1 and a bit-index counts 0..WIDTH+4.
- IDLE:
  - tx_out=1.
  - If hold_valid: on the next edge, load the shifter with the frame, clear hold_valid, reset bit-index and bit-timer, and go to SHIFT.
  - Latency: accept at edge N → start bit on tx_out from edge N+1 → res_ready high again from edge N+1.
- SHIFT:
  - tx_out = current frame bit. Each bit lasts exactly CLKS_PER_BIT cycles.
  - On the final cycle of the stop bit, frame_count increments (255→0 wraps).
  - At that same final cycle of the stop bit: if hold_valid, load the next frame directly with no idle gap, clear hold_valid and stay in SHIFT; otherwise go to IDLE.
- busy = (state==SHIFT) || hold_valid.
- An accept during SHIFT fills the holding register only. The frame in progress is unaffected.
- Reset mid-frame: tx_out=1 from the next edge. The held result is discarded, frame_count=0 and the FSM returns to IDLE. No partial frame resumes.
- tx_out is driven from a register with no glitches.

Test Plan:
1. Reset: assert rst for 3 cycles → tx_out=1, res_ready=1, busy=0, frame_count=0. Hold res_valid=1 during reset → nothing is accepted.
2. Single frame: res_data=4'h5, carry=0, zero=0, one-cycle valid → tx_out carries 0,1,0,1,0,0,0,0,1, each for 4 cycles (36 cycles total), starting the edge after accept. Then frame_count=1, busy=0.
3. Parity cases:
   - res_data=4'hF, carry=1, zero=0 → parity bit 1.
   - res_data=4'h0, carry=1, zero=1 → parity bit 0; frame is 0,0,0,0,0,1,1,0,1.
4. Back-to-back and backpressure:
   - Present results 4'h3, 4'h2 and 4'h9 with res_valid held high.
   - 4'h3 is accepted and 4'h2 is held; res_ready=0 while 4'h2 is held, so 4'h9 is not accepted.
   - The 4'h2 frame starts the cycle after the 4'h3 stop bit, with no idle cycle.
   - 4'h9 is accepted once 4'h2 leaves the holding register.
   - frame_count increments once per frame.
5. Reset mid-frame: assert rst during the third data bit with a result held → tx_out=1 next cycle, held result discarded, no further frames, frame_count=0.
6. Wrap: send 256 frames with CLKS_PER_BIT=1 → frame_count returns to 0; the 257th frame gives frame_count=1.

Source files
------------

// File: rtl/alu_result_serializer.sv
// -----------------------------------------------------------------------------
// alu_result_serializer
//
// Purpose:
//   Takes each ALU result (data plus carry and zero flags) through a
//   valid/ready handshake and sends it out on one pin as a UART-style frame.
//   A single holding register lets the next result wait while the previous
//   frame is still shifting, so back-to-back frames run with no idle gap.
//
//   Frame, in transmit order (WIDTH+5 bits):
//     start(0), data[0..WIDTH-1], carry, zero, even parity, stop(1)
//
// Handshake (valid/ready):
//   A result is transferred on a rising edge where res_valid && res_ready.
//   res_ready is high exactly when the holding register is empty and comes
//   from registered state only. While res_ready is low, res_valid and the
//   data inputs are ignored. Once res_valid is raised the source keeps the
//   data stable until the transfer edge.
//
// Ports:
//   clk          system clock, rising edge
//   rst          synchronous reset, active-high
//   res_valid    result present on res_data/res_carry/res_zero
//   res_ready    holding register empty; a result is accepted this cycle
//   res_data     ALU result
//   res_carry    ALU carry/borrow flag
//   res_zero     ALU zero flag
//   tx_out       serial frame output, idles high, driven from a register
//   busy         a frame is shifting or a result is held
//   frame_count  number of completed frames, wraps at 256
//   dbg_state_o  FSM state (0 = IDLE, 1 = SHIFT)
// -----------------------------------------------------------------------------
module alu_result_serializer #(
    parameter int WIDTH        = 4,
    parameter int CLKS_PER_BIT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             res_valid,
    output logic             res_ready,
    input  logic [WIDTH-1:0] res_data,
    input  logic             res_carry,
    input  logic             res_zero,
    output logic             tx_out,
    output logic             busy,
    output logic [7:0]       frame_count,
    output logic             dbg_state_o
);

    localparam int FRAME_W = WIDTH + 5;
    localparam int TMR_W   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int IDX_W   = $clog2(FRAME_W);

    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(FRAME_W - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_e;

    state_e             state_q, state_d;
    logic               hold_valid_q, hold_valid_d;
    logic [FRAME_W-1:0] hold_frame_q, hold_frame_d;
    logic [FRAME_W-1:0] shift_q, shift_d;
    logic [TMR_W-1:0]   timer_q, timer_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [7:0]         count_q, count_d;

    logic               accept;
    logic               load;
    logic [FRAME_W-1:0] new_frame;

    // The frame is assembled at accept time, so the holding register already
    // contains exactly what the shifter will send. Bit 0 goes out first.
    assign new_frame = {1'b1, ^{res_data, res_carry, res_zero},
                        res_zero, res_carry, res_data, 1'b0};

    assign accept = res_valid && !hold_valid_q;

    always_comb begin
        state_d      = state_q;
        hold_valid_d = hold_valid_q;
        hold_frame_d = hold_frame_q;
        shift_d      = shift_q;
        timer_d      = timer_q;
        idx_d        = idx_q;
        count_d      = count_q;
        load         = 1'b0;

        case (state_q)
            IDLE: begin
                if (hold_valid_q) begin
                    load = 1'b1;
                end
            end
            SHIFT: begin
                if (timer_q == TMR_LAST) begin
                    timer_d = '0;
                    if (idx_q == IDX_LAST) begin
                        // Last cycle of the stop bit: frame complete. Chain
                        // straight into a held result, otherwise go quiet.
                        count_d = count_q + 8'd1;
                        if (hold_valid_q) begin
                            load = 1'b1;
                        end else begin
                            state_d = IDLE;
                            shift_d = '1;
                        end
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        // Ones are shifted in so the line rests high once the
                        // stop bit has gone out.
                        shift_d = {1'b1, shift_q[FRAME_W-1:1]};
                    end
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // load only happens with the holding register full and accept only
        // with it empty, so the two never collide.
        if (load) begin
            shift_d      = hold_frame_q;
            hold_valid_d = 1'b0;
            timer_d      = '0;
            idx_d        = '0;
            state_d      = SHIFT;
        end

        if (accept) begin
            hold_valid_d = 1'b1;
            hold_frame_d = new_frame;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            hold_valid_q <= 1'b0;
            hold_frame_q <= '0;
            shift_q      <= '1;
            timer_q      <= '0;
            idx_q        <= '0;
            count_q      <= '0;
        end else begin
            state_q      <= state_d;
            hold_valid_q <= hold_valid_d;
            hold_frame_q <= hold_frame_d;
            shift_q      <= shift_d;
            timer_q      <= timer_d;
            idx_q        <= idx_d;
            count_q      <= count_d;
        end
    end

    assign tx_out      = shift_q[0];
    assign res_ready   = !hold_valid_q;
    assign busy        = (state_q == SHIFT) || hold_valid_q;
    assign frame_count = count_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_alu_result_serializer.sv
// -----------------------------------------------------------------------------
// tb_alu_result_serializer
//
// Two instances: dut_a with CLKS_PER_BIT=4 for the frame, parity, handshake
// and reset scenarios, dut_b with CLKS_PER_BIT=1 for the frame_count wrap.
// A bench-side model tracks, per instance, the frame on the wire and how many
// cycles of it are left, plus the held frame and the completed-frame count.
// -----------------------------------------------------------------------------
module tb_alu_result_serializer;

    localparam int W    = 4;
    localparam int FW   = W + 5;
    localparam int CPBA = 4;
    localparam int CPBB = 1;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_a, va, ca, za;
    logic [W-1:0] da;
    logic         ready_a, tx_a, busy_a, st_a;
    logic [7:0]   fc_a;

    logic         rst_b, vb, cb, zb;
    logic [W-1:0] db;
    logic         ready_b, tx_b, busy_b, st_b;
    logic [7:0]   fc_b;

    alu_result_serializer #(.WIDTH(W), .CLKS_PER_BIT(CPBA)) dut_a (
        .clk(clk), .rst(rst_a), .res_valid(va), .res_ready(ready_a),
        .res_data(da), .res_carry(ca), .res_zero(za), .tx_out(tx_a),
        .busy(busy_a), .frame_count(fc_a), .dbg_state_o(st_a)
    );

    alu_result_serializer #(.WIDTH(W), .CLKS_PER_BIT(CPBB)) dut_b (
        .clk(clk), .rst(rst_b), .res_valid(vb), .res_ready(ready_b),
        .res_data(db), .res_carry(cb), .res_zero(zb), .tx_out(tx_b),
        .busy(busy_b), .frame_count(fc_b), .dbg_state_o(st_b)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic timeout_fail(input string name);
        checks++;
        failures++;
        $display("FAIL %s timed out t=%0t", name, $time);
    endtask

    // ---------------- model ----------------
    // Frame in transmit order: index 0 is sent first.
    function automatic logic [FW-1:0] build_frame(input logic [W-1:0] d, input logic c, input logic z);
        logic [FW-1:0] f;
        int ones;
        ones = 0;
        f[0] = 1'b0;
        for (int k = 0; k < W; k++) begin
            f[1+k] = d[k];
            if (d[k]) ones++;
        end
        f[W+1] = c;
        f[W+2] = z;
        if (c) ones++;
        if (z) ones++;
        f[W+3] = (ones % 2 == 1);
        f[W+4] = 1'b1;
        return f;
    endfunction

    function automatic int cpb(input int i);
        return (i == 0) ? CPBA : CPBB;
    endfunction

    logic [FW-1:0] m_frame[2];
    logic [FW-1:0] m_hold_frame[2];
    int            m_rem[2];   // cycles of the current frame still to go
    bit            m_hold[2];
    int            m_cnt[2];
    bit            m_init[2];

    initial begin
        for (int i = 0; i < 2; i++) begin
            m_frame[i] = '1; m_hold_frame[i] = '0; m_rem[i] = 0;
            m_hold[i] = 0; m_cnt[i] = 0; m_init[i] = 0;
        end
    end

    // One rising edge, given the inputs as they were before it.
    task automatic model_step(input int i, input logic r, input logic v,
                              input logic [W-1:0] d, input logic c, input logic z);
        bit hold_pre;
        if (r) begin
            m_hold[i] = 0;
            m_rem[i]  = 0;
            m_cnt[i]  = 0;
            m_init[i] = 1;
        end else begin
            hold_pre = m_hold[i];
            if (m_rem[i] > 0) begin
                m_rem[i]--;
                if (m_rem[i] == 0) m_cnt[i]++;
            end
            if (m_rem[i] == 0 && hold_pre) begin
                m_frame[i] = m_hold_frame[i];
                m_rem[i]   = FW * cpb(i);
                m_hold[i]  = 0;
            end
            if (v && !hold_pre) begin
                m_hold[i]       = 1;
                m_hold_frame[i] = build_frame(d, c, z);
            end
        end
    endtask

    always @(posedge clk) begin
        model_step(0, rst_a, va, da, ca, za);
        model_step(1, rst_b, vb, db, cb, zb);
    end

    // ---------------- scoreboard compare, every cycle ----------------
    task automatic cmp(input int i, input logic tx, input logic rdy,
                       input logic bsy, input logic [7:0] fc, input logic st);
        logic exp_tx;
        int   pos;
        if (m_rem[i] == 0) begin
            exp_tx = 1'b1;
        end else begin
            pos    = (FW * cpb(i) - m_rem[i]) / cpb(i);
            exp_tx = m_frame[i][pos];
        end
        chk($sformatf("dut%0d_tx", i), 32'(tx), 32'(exp_tx));
        chk($sformatf("dut%0d_ready", i), 32'(rdy), 32'(!m_hold[i]));
        chk($sformatf("dut%0d_busy", i), 32'(bsy), 32'((m_rem[i] > 0) || m_hold[i]));
        chk($sformatf("dut%0d_count", i), 32'(fc), 32'(m_cnt[i] % 256));
        chk($sformatf("dut%0d_state", i), 32'(st), 32'(m_rem[i] > 0));
    endtask

    always @(negedge clk) begin
        if (m_init[0]) cmp(0, tx_a, ready_a, busy_a, fc_a, st_a);
        if (m_init[1]) cmp(1, tx_b, ready_b, busy_b, fc_b, st_b);
    end

    // ---------------- driver tasks ----------------
    task automatic send_a(input logic [W-1:0] d, input logic c, input logic z, input bit keep);
        logic r;
        int   n;
        da = d; ca = c; za = z; va = 1'b1;
        n = 0;
        do begin
            r = ready_a;
            @(negedge clk);
            n++;
        end while (!r && n < 400);
        if (!r) timeout_fail("send_a");
        if (!keep) va = 1'b0;
    endtask

    task automatic send_b(input logic [W-1:0] d, input logic c, input logic z);
        logic r;
        int   n;
        db = d; cb = c; zb = z; vb = 1'b1;
        n = 0;
        do begin
            r = ready_b;
            @(negedge clk);
            n++;
        end while (!r && n < 100);
        if (!r) timeout_fail("send_b");
        vb = 1'b0;
    endtask

    task automatic wait_tx_low_a();
        int n;
        n = 0;
        while (tx_a !== 1'b0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (tx_a !== 1'b0) timeout_fail("wait_tx_low_a");
    endtask

    task automatic wait_idle_a();
        int n;
        n = 0;
        while (busy_a !== 1'b0 && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (busy_a !== 1'b0) timeout_fail("wait_idle_a");
    endtask

    task automatic wait_idle_b();
        int n;
        n = 0;
        while (busy_b !== 1'b0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (busy_b !== 1'b0) timeout_fail("wait_idle_b");
    endtask

    // Samples the first cycle of each bit, starting at the first start-bit cycle.
    task automatic capture_a(output logic [FW-1:0] f);
        wait_tx_low_a();
        for (int b = 0; b < FW; b++) begin
            f[b] = tx_a;
            repeat (CPBA) @(negedge clk);
        end
    endtask

    // ---------------- main sequence ----------------
    logic [FW-1:0] cap;

    initial begin
        rst_a = 1'b1; rst_b = 1'b1;
        va = 1'b1; da = 4'h7; ca = 1'b1; za = 1'b0;
        vb = 1'b1; db = 4'hC; cb = 1'b0; zb = 1'b1;

        // Model pinned against hand-built frames.
        chk("model_frame_5", 32'(build_frame(4'h5, 1'b0, 1'b0)), 32'h10A);
        chk("model_frame_0_cz", 32'(build_frame(4'h0, 1'b1, 1'b1)), 32'h160);

        // 1. Reset with valid held high.
        repeat (3) @(negedge clk);
        chk("rst_tx", 32'(tx_a), 32'd1);
        chk("rst_ready", 32'(ready_a), 32'd1);
        chk("rst_busy", 32'(busy_a), 32'd0);
        chk("rst_count", 32'(fc_a), 32'd0);
        rst_a = 1'b0; rst_b = 1'b0; va = 1'b0; vb = 1'b0;
        repeat (3) @(negedge clk);
        chk("post_rst_busy", 32'(busy_a), 32'd0);
        chk("post_rst_busy_b", 32'(busy_b), 32'd0);

        // 2. Single frame 4'h5.
        send_a(4'h5, 1'b0, 1'b0, 0);
        capture_a(cap);
        chk("frame_5", 32'(cap), 32'h10A);
        chk("frame_5_count", 32'(fc_a), 32'd1);
        chk("frame_5_busy", 32'(busy_a), 32'd0);

        // 3. Parity cases.
        send_a(4'hF, 1'b1, 1'b0, 0);
        capture_a(cap);
        chk("parity_F_c", 32'(cap[7]), 32'd1);
        chk("frame_F_c", 32'(cap), 32'h1BE);
        send_a(4'h0, 1'b1, 1'b1, 0);
        capture_a(cap);
        chk("parity_0_cz", 32'(cap[7]), 32'd0);
        chk("frame_0_cz", 32'(cap), 32'h160);
        chk("parity_count", 32'(fc_a), 32'd3);

        // 4. Back-to-back with backpressure, valid held high throughout.
        send_a(4'h3, 1'b0, 1'b0, 1);
        send_a(4'h2, 1'b0, 1'b0, 1);
        chk("b2b_ready_held", 32'(ready_a), 32'd0);
        send_a(4'h9, 1'b0, 1'b0, 0);
        wait_idle_a();
        chk("b2b_count", 32'(fc_a), 32'd6);

        // 5. Reset during the third data bit with a result held.
        send_a(4'h6, 1'b0, 1'b0, 0);
        wait_tx_low_a();
        send_a(4'hA, 1'b1, 1'b0, 0);
        chk("midrst_held", 32'(busy_a && !ready_a), 32'd1);
        repeat (11) @(negedge clk);
        rst_a = 1'b1;
        @(negedge clk);
        rst_a = 1'b0;
        chk("midrst_tx", 32'(tx_a), 32'd1);
        chk("midrst_busy", 32'(busy_a), 32'd0);
        chk("midrst_count", 32'(fc_a), 32'd0);
        chk("midrst_ready", 32'(ready_a), 32'd1);
        repeat (60) @(negedge clk);
        chk("midrst_quiet_count", 32'(fc_a), 32'd0);
        chk("midrst_quiet_busy", 32'(busy_a), 32'd0);

        // 6. frame_count wrap on the CLKS_PER_BIT=1 instance.
        for (int i = 0; i < 256; i++) begin
            send_b(i[3:0], i[4], i[5]);
        end
        wait_idle_b();
        chk("wrap_256", 32'(fc_b), 32'd0);
        send_b(4'hB, 1'b1, 1'b0);
        wait_idle_b();
        chk("wrap_257", 32'(fc_b), 32'd1);

        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
